// File: rtl/sram_1rw1r_wmask.sv
// Behavioural SRAM with one read/write port and one read-only port on a single clock.
// Byte write masking, selectable read-during-write policy on port 1, and an optional clear sweep.
module sram_1rw1r_wmask #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 7,
  parameter int WMASK_WIDTH    = DATA_WIDTH / 8,
  parameter int WRITE_FIRST    = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter int VERBOSE        = 1
) (
  input  logic                   clk0,
  input  logic                   rst0,
  input  logic                   csb0,
  input  logic                   web0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  output logic [DATA_WIDTH-1:0]  dout0,
  output logic                   dvalid0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dvalid1,
  output logic                   ready
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_READY} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0]   wr_word;
  logic [DATA_WIDTH-1:0]   rd1_word;
  logic                    accept;
  logic                    rd0;
  logic                    wr0;
  logic                    rd1;
  logic                    x0;
  logic                    x1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk0) begin
    if (rst0) state <= ST_RESET;
    else      state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      ST_CLEAR: if (clr_cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) state_nxt = ST_READY;
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_RESET;
    endcase
  end

  assign ready  = (state == ST_READY);
  assign accept = ready && !rst0;
  assign wr0    = accept && !csb0 && !web0;
  assign rd0    = accept && !csb0 && web0;
  assign rd1    = accept && !csb1;
  assign x0     = accept && $isunknown({csb0, web0});
  assign x1     = accept && $isunknown(csb1);

  always_comb begin
    wr_word = mem[addr0];
    for (int i = 0; i < WMASK_WIDTH; i++) begin
      if (wmask0[i]) wr_word[8*i +: 8] = din0[8*i +: 8];
    end
  end

  // Port 1 sees the merged word only when it collides with a port 0 write in write-first mode.
  assign rd1_word = ((WRITE_FIRST != 0) && wr0 && (addr0 == addr1)) ? wr_word : mem[addr1];

  always_ff @(posedge clk0) begin
    if (rst0)                    clr_cnt <= '0;
    else if (state == ST_CLEAR)  clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
  end

  // NOTE: the array has no reset branch; contents survive reset and are only zeroed by the sweep.
  always_ff @(posedge clk0) begin
    if (!rst0 && (state == ST_CLEAR)) mem[clr_cnt] <= '0;
    else if (wr0)                     mem[addr0]   <= wr_word;
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      dout0   <= '0;
      dout1   <= '0;
      dvalid0 <= 1'b0;
      dvalid1 <= 1'b0;
    end else begin
      dvalid0 <= 1'b0;
      dvalid1 <= 1'b0;
      if (x0) begin
        dout0 <= 'x;
        $warning("%0t port0 unknown control csb0=%b web0=%b", $time, csb0, web0);
      end else if (rd0) begin
        dout0   <= mem[addr0];
        dvalid0 <= 1'b1;
        if (VERBOSE != 0) $info("%0t port0 read addr=%0h data=%0h", $time, addr0, mem[addr0]);
      end else if (wr0 && (VERBOSE != 0)) begin
        $info("%0t port0 write addr=%0h data=%0h mask=%0b", $time, addr0, din0, wmask0);
      end
      if (x1) begin
        dout1 <= 'x;
        $warning("%0t port1 unknown control csb1=%b", $time, csb1);
      end else if (rd1) begin
        dout1   <= rd1_word;
        dvalid1 <= 1'b1;
        if (VERBOSE != 0) $info("%0t port1 read addr=%0h data=%0h", $time, addr1, rd1_word);
      end
    end
  end

endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// Directed bench: instance a is write-first with clear sweep, instance b is read-first without clear.
module tb_sram_1rw1r_wmask;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, csb0, web0, csb1, dvalid0, dvalid1, ready;
  logic [3:0]  wmask0;
  logic [6:0]  addr0, addr1;
  logic [31:0] din0, dout0, dout1;

  logic        rst_b, b_csb0, b_web0, b_csb1, b_dvalid0, b_dvalid1, b_ready;
  logic [3:0]  b_wmask0;
  logic [6:0]  b_addr0, b_addr1;
  logic [31:0] b_din0, b_dout0, b_dout1;

  int total = 0;
  int bad   = 0;

  sram_1rw1r_wmask #(.WRITE_FIRST(1), .CLEAR_ON_RESET(1), .VERBOSE(0)) dut_a (
    .clk0(clk), .rst0(rst_a), .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0),
    .din0(din0), .dout0(dout0), .dvalid0(dvalid0), .csb1(csb1), .addr1(addr1),
    .dout1(dout1), .dvalid1(dvalid1), .ready(ready)
  );

  sram_1rw1r_wmask #(.WRITE_FIRST(0), .CLEAR_ON_RESET(0), .VERBOSE(0)) dut_b (
    .clk0(clk), .rst0(rst_b), .csb0(b_csb0), .web0(b_web0), .wmask0(b_wmask0), .addr0(b_addr0),
    .din0(b_din0), .dout0(b_dout0), .dvalid0(b_dvalid0), .csb1(b_csb1), .addr1(b_addr1),
    .dout1(b_dout1), .dvalid1(b_dvalid1), .ready(b_ready)
  );

  typedef struct {
    logic        c0, w0;
    logic [3:0]  m;
    logic [6:0]  a0;
    logic [31:0] d0;
    logic        c1;
    logic [6:0]  a1;
    logic        dv0;
    logic [31:0] e0;
    logic        dv1;
    logic [31:0] e1;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  function automatic vec_t mk(logic c0, logic w0, logic [3:0] m, logic [6:0] a0, logic [31:0] d0,
                              logic c1, logic [6:0] a1, logic dv0, logic [31:0] e0,
                              logic dv1, logic [31:0] e1);
    vec_t v;
    v.c0 = c0; v.w0 = w0; v.m = m; v.a0 = a0; v.d0 = d0; v.c1 = c1; v.a1 = a1;
    v.dv0 = dv0; v.e0 = e0; v.dv1 = dv1; v.e1 = e1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = 4'h0; addr0 = '0; addr1 = '0; din0 = '0;
  endtask

  task automatic idle_b();
    b_csb0 = 1'b1; b_web0 = 1'b1; b_csb1 = 1'b1; b_wmask0 = 4'h0;
    b_addr0 = '0; b_addr1 = '0; b_din0 = '0;
  endtask

  // Steps until ready rises (bounded); every blocked edge must leave both dvalids low.
  task automatic wait_ready(input int start, output int n);
    n = start;
    while (!ready && n < 400) begin
      step();
      n++;
      check("blocked_dvalid", {30'd0, dvalid0, dvalid1}, 32'd0);
    end
  endtask

  initial begin
    int n;
    idle_a();
    idle_b();
    rst_a = 1'b1;
    rst_b = 1'b1;
    step();
    step();
    check("rst_ready_a", {31'd0, ready}, 32'd0);
    check("rst_ready_b", {31'd0, b_ready}, 32'd0);
    check("rst_dout0", dout0, 32'd0);
    check("rst_dout1", dout1, 32'd0);
    check("rst_dvalid", {30'd0, dvalid0, dvalid1}, 32'd0);

    // Release both; b has no sweep so it is ready after one edge.
    rst_a = 1'b0;
    rst_b = 1'b0;
    step();
    check("rel_ready_a", {31'd0, ready}, 32'd0);
    check("rel_ready_b", {31'd0, b_ready}, 32'd1);
    wait_ready(1, n);
    check("clear_edges", n, 32'd129);

    for (int a = 0; a < 128; a++) begin
      csb0 = 1'b0; web0 = 1'b1; addr0 = 7'(a);
      csb1 = 1'b0; addr1 = 7'(127 - a);
      step();
      check($sformatf("clr_rd0_%0d", a), {dvalid0, dout0[30:0]} ^ 32'h8000_0000 | {1'b0, dout0[31], 30'd0}, 32'd0);
      check($sformatf("clr_rd1_%0d", a), dout1, 32'd0);
      check($sformatf("clr_dv1_%0d", a), {31'd0, dvalid1}, 32'd1);
    end

    vecs[0]  = mk(0, 0, 4'hF, 7'd5,   32'hAABBCCDD, 1, 7'd0,   0, 32'h0,        0, 32'h0);
    vecs[1]  = mk(0, 0, 4'h5, 7'd5,   32'h11223344, 0, 7'd5,   0, 32'h0,        1, 32'hAA22CC44);
    vecs[2]  = mk(0, 1, 4'h0, 7'd5,   32'h0,        1, 7'd0,   1, 32'hAA22CC44, 0, 32'hAA22CC44);
    vecs[3]  = mk(1, 1, 4'h0, 7'd0,   32'h0,        1, 7'd0,   0, 32'hAA22CC44, 0, 32'hAA22CC44);
    vecs[4]  = mk(0, 0, 4'hF, 7'd9,   32'hDEADBEEF, 0, 7'd9,   0, 32'hAA22CC44, 1, 32'hDEADBEEF);
    vecs[5]  = mk(0, 1, 4'h0, 7'd9,   32'h0,        0, 7'd5,   1, 32'hDEADBEEF, 1, 32'hAA22CC44);
    vecs[6]  = mk(0, 0, 4'h0, 7'd5,   32'hFFFFFFFF, 0, 7'd5,   0, 32'hDEADBEEF, 1, 32'hAA22CC44);
    vecs[7]  = mk(0, 1, 4'h0, 7'd5,   32'h0,        0, 7'd5,   1, 32'hAA22CC44, 1, 32'hAA22CC44);
    vecs[8]  = mk(0, 0, 4'hF, 7'd20,  32'h12345678, 1, 7'd0,   0, 32'hAA22CC44, 0, 32'hAA22CC44);
    vecs[9]  = mk(1, 1, 4'h0, 7'd0,   32'h0,        0, 7'd20,  0, 32'hAA22CC44, 1, 32'h12345678);
    vecs[10] = mk(1, 1, 4'h0, 7'd0,   32'h0,        1, 7'd0,   0, 32'hAA22CC44, 0, 32'h12345678);
    vecs[11] = mk(1, 1, 4'h0, 7'd0,   32'h0,        1, 7'd0,   0, 32'hAA22CC44, 0, 32'h12345678);
    vecs[12] = mk(1, 1, 4'h0, 7'd0,   32'h0,        1, 7'd0,   0, 32'hAA22CC44, 0, 32'h12345678);
    vecs[13] = mk(0, 0, 4'h8, 7'd127, 32'h99000000, 0, 7'd0,   0, 32'hAA22CC44, 1, 32'h0);
    vecs[14] = mk(0, 1, 4'h0, 7'd127, 32'h0,        0, 7'd127, 1, 32'h99000000, 1, 32'h99000000);
    vecs[15] = mk(0, 0, 4'h2, 7'd0,   32'hCAFEF00D, 0, 7'd0,   0, 32'h99000000, 1, 32'h0000F000);

    for (int i = 0; i < NV; i++) begin
      csb0 = vecs[i].c0; web0 = vecs[i].w0; wmask0 = vecs[i].m; addr0 = vecs[i].a0;
      din0 = vecs[i].d0; csb1 = vecs[i].c1; addr1 = vecs[i].a1;
      step();
      check($sformatf("vec%0d_dvalid0", i), {31'd0, dvalid0}, {31'd0, vecs[i].dv0});
      check($sformatf("vec%0d_dout0", i), dout0, vecs[i].e0);
      check($sformatf("vec%0d_dvalid1", i), {31'd0, dvalid1}, {31'd0, vecs[i].dv1});
      check($sformatf("vec%0d_dout1", i), dout1, vecs[i].e1);
    end

    // Streaming: write k at address k, port 1 reads what was written the cycle before.
    for (int k = 0; k <= 16; k++) begin
      idle_a();
      if (k < 16) begin
        csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 7'(k); din0 = 32'(k);
      end
      if (k >= 1) begin
        csb1 = 1'b0; addr1 = 7'(k - 1);
      end
      step();
      if (k >= 1) begin
        check($sformatf("stream_dout1_%0d", k), dout1, 32'(k - 1));
        check($sformatf("stream_dv1_%0d", k), {31'd0, dvalid1}, 32'd1);
      end
    end
    idle_a();

    // Read-first collision on instance b.
    b_csb0 = 1'b0; b_web0 = 1'b0; b_wmask0 = 4'hF; b_addr0 = 7'd9; b_din0 = 32'h0;
    step();
    b_din0 = 32'hDEADBEEF; b_csb1 = 1'b0; b_addr1 = 7'd9;
    step();
    check("b_coll_dout1", b_dout1, 32'h0);
    check("b_coll_dv1", {31'd0, b_dvalid1}, 32'd1);
    b_web0 = 1'b1;
    step();
    check("b_after_dout0", b_dout0, 32'hDEADBEEF);
    check("b_after_dout1", b_dout1, 32'hDEADBEEF);

    // Requests during reset and at the release edge of b must be dropped.
    b_web0 = 1'b0; b_din0 = 32'h55555555;
    rst_b = 1'b1;
    step();
    step();
    check("b_rst_dv", {30'd0, b_dvalid0, b_dvalid1}, 32'd0);
    rst_b = 1'b0;
    step();
    check("b_rel_ready", {31'd0, b_ready}, 32'd1);
    check("b_rel_dv", {30'd0, b_dvalid0, b_dvalid1}, 32'd0);
    idle_b();
    b_csb0 = 1'b0; b_addr0 = 7'd9;
    step();
    check("b_mem9_kept", b_dout0, 32'hDEADBEEF);
    idle_b();

    // Reset in the middle of a sweep on instance a, with requests held throughout.
    rst_a = 1'b1;
    step();
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_dout1", dout1, 32'd0);
    csb0 = 1'b0; web0 = 1'b0; wmask0 = 4'hF; addr0 = 7'd3; din0 = 32'h55555555;
    csb1 = 1'b0; addr1 = 7'd3;
    rst_a = 1'b0;
    for (int i = 0; i < 61; i++) begin
      step();
      check($sformatf("mid_sweep_ready_%0d", i), {31'd0, ready}, 32'd0);
      check($sformatf("mid_sweep_dv_%0d", i), {30'd0, dvalid0, dvalid1}, 32'd0);
    end
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    wait_ready(0, n);
    idle_a();
    check("resweep_edges", n, 32'd129);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 7'd3; csb1 = 1'b0; addr1 = 7'd20;
    step();
    check("resweep_mem3", dout0, 32'h0);
    check("resweep_mem20", dout1, 32'h0);
    check("resweep_dv", {30'd0, dvalid0, dvalid1}, 32'd3);
    idle_a();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_1rw1r_wmask.md
# sram_1rw1r_wmask

Parametrised behavioural SRAM model with one read/write port (port 0) and one read-only port (port 1), both on a single clock. It adds byte-granular write masking, a defined read-during-write collision policy, a synchronous reset, and an optional memory-clear sweep after reset. It is the successor to the team's single-port 1RW SRAM models and is used for both simulation and macro-level verification.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 7, address width; RAM_DEPTH = 1 << ADDR_WIDTH.
- WMASK_WIDTH, DATA_WIDTH/8, number of byte write enables.
- WRITE_FIRST, 1, port-1 collision policy: 1 returns new data, 0 returns old data.
- CLEAR_ON_RESET, 1, 1 zeroes all words after reset; 0 leaves contents untouched.
- VERBOSE, 1, 0 prints warnings only; 1 also prints every accepted read and write.

- clk0, in, 1: the only clock; all logic is on posedge.
- rst0, in, 1: synchronous, active-high reset.
- csb0, in, 1: port 0 chip select, active low.
- web0, in, 1: port 0 write enable, active low.
- wmask0, in, WMASK_WIDTH: byte enables; bit i covers din0[8i+7:8i].
- addr0, in, ADDR_WIDTH: port 0 address.
- din0, in, DATA_WIDTH: port 0 write data.
- dout0, out, DATA_WIDTH: port 0 read data.
- dvalid0, out, 1: dout0 was updated by the previous-edge read.
- csb1, in, 1: port 1 chip select, active low.
- addr1, in, ADDR_WIDTH: port 1 address.
- dout1, out, DATA_WIDTH: port 1 read data.
- dvalid1, out, 1: dout1 was updated by the previous-edge read.
- ready, out, 1: the model accepts requests.

## Operation
- States are RESET, CLEAR and READY.
  - rst0 high at a posedge forces RESET, regardless of the current state.
  - RESET goes to CLEAR when CLEAR_ON_RESET=1, otherwise to READY, at the first posedge with rst0 low.
- Reset values, applied at the reset edge:
  - dout0 = 0, dout1 = 0, dvalid0 = 0, dvalid1 = 0, ready = 0.
  - The clear counter is 0.
  - Memory contents are not touched.
- CLEAR sweep:
  - Each posedge with rst0 low writes 0 to mem[counter] and increments the counter.
  - The edge that writes address RAM_DEPTH-1 moves the FSM to READY and sets ready = 1.
  - Reset during CLEAR restarts the sweep from address 0.
- Request acceptance:
  - A request is accepted at a posedge only if ready = 1 before the edge and rst0 = 0.
  - Requests at any other edge are ignored: no memory change, and dvalid stays 0.
- Port 0 write (csb0=0, web0=0):
  - Only the enabled bytes of mem[addr0] are updated, to the matching din0 bytes.
  - wmask0 = 0 is a legal no-op write.
  - dout0 holds its value and dvalid0 = 0.
- Port 0 read (csb0=0, web0=1): dout0 takes mem[addr0] and dvalid0 = 1 for exactly one cycle.
- Port 1 read (csb1=0): dout1 takes mem[addr1] and dvalid1 = 1 for one cycle.
- Idle port: dout holds its last value (never X) and dvalid = 0.
- Collision, meaning port 0 writes and port 1 reads the same address at the same edge:
  - WRITE_FIRST=1: dout1 is the post-write merged word.
  - WRITE_FIRST=0: dout1 is the pre-write word.
  - The memory always ends with the merged word.
- Both ports reading the same address at the same edge is legal; both return the same word.
- Addresses use the full ADDR_WIDTH with no wrap logic; every address is valid.
- Unknown-value warnings: an X or Z on csb0, web0 or csb1 at an edge where ready = 1 prints a warning, and the affected port's dout becomes X for that cycle.

## Timing
- Read latency is 1 cycle: a request at posedge N gives data and dvalid on the outputs from posedge N until posedge N+1.
- A write at posedge N is visible to any read accepted at posedge N+1 or later.
- Back-to-back accesses are allowed on both ports, one per cycle per port.
- ready timing after reset release with CLEAR_ON_RESET=1:
  - The first posedge with rst0 low is the RESET→CLEAR edge.
  - The next RAM_DEPTH edges perform the writes.
  - ready rises after posedge RAM_DEPTH+1, counted from the first rst0-low edge.
- ready timing with CLEAR_ON_RESET=0: ready rises after the first posedge with rst0 low.
- VERBOSE messages print at the accepting edge and include $time, port, address and data.

## Test plan
- Clear sweep: reset for 2 cycles with CLEAR_ON_RESET=1 and ADDR_WIDTH=7, then read all 128 words on both ports.
  - ready rises 129 edges after release.
  - Every read returns 0.
- Masked write: write 0xAABBCCDD to address 5 with wmask0 = 4'b1111, then write 0x11223344 with wmask0 = 4'b0101, then read address 5 on port 0.
  - dout0 = 0xAA22CC44 one cycle after the read edge, with a single-cycle dvalid0.
- Collision: mem[9] = 0x0; port 0 writes 0xDEADBEEF (full mask) to address 9 while port 1 reads address 9 at the same edge.
  - dout1 = 0xDEADBEEF with WRITE_FIRST=1.
  - dout1 = 0x0 with WRITE_FIRST=0.
  - mem[9] = 0xDEADBEEF afterwards in both cases.
- Reset mid-clear: assert rst0 at sweep address 60, then release.
  - ready stays 0 until a full fresh 129-edge sweep completes.
  - Requests issued while ready = 0 leave the memory and dvalid unchanged.
- Hold behaviour: port 1 reads 0x12345678, then is idle for 3 cycles.
  - dout1 stays 0x12345678 and dvalid1 = 0 for all 3 cycles.
- Dual-port streaming: port 0 writes addresses 0..15 with value = address while port 1 reads address k-1 in each cycle k.
  - Each dout1 equals the previous cycle's write value.
